// File: rtl/multi_pop_dispatch_pkg.sv
// Shared types and helpers for the multi-pop dispatcher and its credit counter.
// Lane vectors are handled zero-extended to MAX_LANES bits so one helper serves every width.
package multi_pop_dispatch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_LANES = 32;

    function automatic int popcount(input logic [MAX_LANES-1:0] v, input int width);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < width && v[i]) begin
                c++;
            end
        end
        return c;
    endfunction

    function automatic logic [MAX_LANES-1:0] therm_mask(input int k);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < k) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/multi_pop_dispatch_credit_counter.sv
// Saturating credit pool: count <= count - spend + credit_ret + restore, clamped at CREDITS.
// Spend never exceeds count, so the subtraction cannot wrap.
module credit_counter
    import multi_pop_dispatch_pkg::*;
#(
    parameter int CREDITS = 8,
    parameter int DW      = 3,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] spend,
    input  logic [DW-1:0] credit_ret,
    input  logic [DW-1:0] restore,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int SW = ((CW > DW) ? CW : DW) + 2;

    logic [SW-1:0] sum;

    assign sum  = SW'(count) - SW'(spend) + SW'(credit_ret) + SW'(restore);
    assign full = (count == CW'(CREDITS));

    // Returning more than was spent is a downstream protocol error; clamp rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CW'(CREDITS);
        end else if (sum > SW'(CREDITS)) begin
            count <= CW'(CREDITS);
        end else begin
            count <= CW'(sum);
        end
    end

endmodule

// File: rtl/multi_pop_dispatch.sv
// In-order credit-gated dispatcher: pops up to N FIFO entries per cycle into a registered N-lane stage
// (pop at t -> out_valid at t+1) and sequences FIFO flush; MULTI_POP_DISPATCH_PERF_EN adds perf counters.
module multi_pop_dispatch
    import multi_pop_dispatch_pkg::*;
#(
    parameter type T       = logic [7:0],
    parameter int  N       = 4,
    parameter int  DEPTH   = 16,
    parameter int  CREDITS = 8,
    localparam int DEPTH_BITS = $clog2(DEPTH),
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  T                    fifo_dataout [N],
    input  logic [DEPTH_BITS:0] fifo_entry_count,
    output logic [N-1:0]        fifo_pop,
    output logic                fifo_clear,
    output logic [N-1:0]        out_valid,
    output T                    out_data [N],
    input  logic                out_ready,
    input  logic [N-1:0]        credit_return,
    input  logic                flush,
    output logic [CW-1:0]       credit_avail,
    output logic                busy
`ifdef MULTI_POP_DISPATCH_PERF_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_credit_stall_cnt
`endif
);

    localparam int KW = $clog2(N + 1);
    localparam int EW = DEPTH_BITS + 1;
    localparam logic [EW-1:0] N_EXT = EW'(N);

    state_t        state, state_nxt;
    logic          stage_free;
    logic [KW-1:0] k, ret_cnt, restore_cnt, valid_cnt;
    logic [CW-1:0] credit_cnt;
    logic          credit_full;

    assign stage_free = (out_valid == '0) || out_ready;
    assign ret_cnt    = KW'(popcount(MAX_LANES'(credit_return), N));
    assign valid_cnt  = KW'(popcount(MAX_LANES'(out_valid), N));

    always_comb begin
        state_nxt   = state;
        k           = '0;
        restore_cnt = '0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = FLUSH;
                    // Held lanes that downstream did not take are handed back to the pool.
                    if (!out_ready) begin
                        restore_cnt = valid_cnt;
                    end
                end else if (stage_free) begin
                    k = KW'(N);
                    if (fifo_entry_count < N_EXT) begin
                        k = KW'(fifo_entry_count);
                    end
                    if (int'(credit_cnt) < int'(k)) begin
                        k = KW'(credit_cnt);
                    end
                end
            end
            FLUSH: state_nxt = DRAIN;
            DRAIN: begin
                if (credit_full) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign fifo_pop     = N'(therm_mask(int'(k)));
    assign fifo_clear   = (state == FLUSH);
    assign credit_avail = credit_cnt;
    assign busy         = (state != RUN) || (out_valid != '0) || (fifo_entry_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= '0;
            for (int i = 0; i < N; i++) begin
                out_data[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                if (flush) begin
                    out_valid <= '0;
                end else if (stage_free) begin
                    out_valid <= fifo_pop;
                    for (int i = 0; i < N; i++) begin
                        if (fifo_pop[i]) begin
                            out_data[i] <= fifo_dataout[i];
                        end
                    end
                end
            end
        end
    end

    credit_counter #(
        .CREDITS (CREDITS),
        .DW      (KW)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .spend      (k),
        .credit_ret (ret_cnt),
        .restore    (restore_cnt),
        .count      (credit_cnt),
        .full       (credit_full)
    );

`ifdef MULTI_POP_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt        <= '0;
            perf_credit_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(k);
            if (state == RUN && stage_free && fifo_entry_count != '0 && credit_cnt == '0) begin
                perf_credit_stall_cnt <= perf_credit_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_pop_dispatch.sv
// Scoreboard bench: a transaction-level model of the dispatcher plus a FIFO emulation drive the DUT.
module tb_multi_pop_dispatch;

    localparam int N       = 4;
    localparam int DEPTH   = 16;
    localparam int CREDITS = 8;
    localparam int M_RUN   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_DRAIN = 2;

    logic       clk;
    logic       rst;
    logic [7:0] fifo_dataout [N];
    logic [4:0] fifo_entry_count;
    logic [3:0] fifo_pop;
    logic       fifo_clear;
    logic [3:0] out_valid;
    logic [7:0] out_data [N];
    logic       out_ready;
    logic [3:0] credit_return;
    logic       flush;
    logic [3:0] credit_avail;
    logic       busy;

    multi_pop_dispatch dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_dataout     (fifo_dataout),
        .fifo_entry_count (fifo_entry_count),
        .fifo_pop         (fifo_pop),
        .fifo_clear       (fifo_clear),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .credit_return    (credit_return),
        .flush            (flush),
        .credit_avail     (credit_avail),
        .busy             (busy)
    );

    // Environment and model state
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    int   m_state, m_avail, m_vcnt, acc_out;
    int   errors, checks;
    logic [7:0] seq;

    // Knobs written only by the main sequence
    int   rdy_pct, flush_pm, ret_mode, ret_pct, push_max, push_n, push_tok;
    logic force_flush;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] thermo(input int n);
        logic [7:0] t;
        t = 8'((1 << n) - 1);
        return t[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Driver: applies the knobs to the DUT pins just after each rising edge.
    initial begin
        flush = 1'b0;
        out_ready = 1'b0;
        credit_return = '0;
        fifo_entry_count = '0;
        for (int i = 0; i < N; i++) fifo_dataout[i] = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            fifo_entry_count = 5'(fifo_q.size());
            for (int i = 0; i < N; i++) fifo_dataout[i] = (i < fifo_q.size()) ? fifo_q[i] : 8'h00;
            out_ready = ($urandom_range(99) < rdy_pct);
            flush = force_flush || ($urandom_range(999) < flush_pm);
            if (ret_mode == 2) begin
                credit_return = 4'b1111;
            end else if (ret_mode == 1 && $urandom_range(99) < ret_pct) begin
                int r, s;
                logic [7:0] m;
                r = $urandom_range(N);
                if (r > acc_out) r = acc_out;
                s = $urandom_range(N - 1);
                m = 8'((1 << r) - 1);
                m = (m << s) | (m >> (N - s));
                credit_return = m[3:0];
            end else begin
                credit_return = '0;
            end
        end
    end

    // Monitor / reference model: compares at the falling edge, then advances to the next cycle.
    initial begin
        int k, st_free, restore, ret, nxt_avail, nxt_vcnt, nxt_state, npop, n, last_tok;
        last_tok = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < m_vcnt; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_state = M_RUN;
                m_avail = CREDITS;
                m_vcnt  = 0;
                acc_out = 0;
                continue;
            end
            st_free = (m_vcnt == 0) || out_ready;
            k = 0;
            if (m_state == M_RUN && st_free && !flush) begin
                k = N;
                if (fifo_q.size() < k) k = fifo_q.size();
                if (m_avail < k) k = m_avail;
            end
            chk("fifo_pop", 32'(fifo_pop), 32'(thermo(k)));
            chk("out_valid", 32'(out_valid), 32'(thermo(m_vcnt)));
            chk("credit_avail", 32'(credit_avail), 32'(m_avail));
            chk("fifo_clear", 32'(fifo_clear), 32'(m_state == M_FLUSH));
            chk("busy", 32'(busy), 32'(m_state != M_RUN || m_vcnt != 0 || fifo_q.size() != 0));

            // Scoreboard: accepted lanes must match the oldest outstanding entries.
            if (m_vcnt > 0 && out_ready) begin
                for (int i = 0; i < m_vcnt; i++) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 32'(exp_q.size()), 32'(1));
                    end else begin
                        chk("out_data", 32'(out_data[i]), 32'(exp_q.pop_front()));
                    end
                end
                acc_out += m_vcnt;
            end else if (m_state == M_RUN && flush && m_vcnt > 0) begin
                for (int i = 0; i < m_vcnt; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            end

            restore = (m_state == M_RUN && flush && !out_ready) ? m_vcnt : 0;
            ret = $countones(credit_return);
            nxt_avail = m_avail - k + ret + restore;
            if (nxt_avail > CREDITS) nxt_avail = CREDITS;
            nxt_state = m_state;
            nxt_vcnt  = 0;
            if (m_state == M_RUN) begin
                if (flush) nxt_state = M_FLUSH;
                else if (st_free) nxt_vcnt = k;
                else nxt_vcnt = m_vcnt;
            end else if (m_state == M_FLUSH) begin
                nxt_state = M_DRAIN;
                exp_q.delete();
            end else if (m_avail == CREDITS) begin
                nxt_state = M_RUN;
            end
            acc_out = (acc_out > ret) ? acc_out - ret : 0;

            // FIFO emulation follows the DUT's own pop/clear requests.
            npop = $countones(fifo_pop);
            for (int i = 0; i < npop; i++) if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_clear) fifo_q.delete();
            if (m_state != M_FLUSH) begin
                if (push_tok != last_tok) begin
                    n = push_n;
                    last_tok = push_tok;
                end else begin
                    n = (push_max > 0) ? $urandom_range(push_max) : 0;
                end
                if (n > DEPTH - fifo_q.size()) n = DEPTH - fifo_q.size();
                for (int i = 0; i < n; i++) begin
                    fifo_q.push_back(seq);
                    exp_q.push_back(seq);
                    seq++;
                end
            end
            m_state = nxt_state;
            m_avail = nxt_avail;
            m_vcnt  = nxt_vcnt;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic push(input int n);
        push_n = n;
        push_tok++;
    endtask

    task automatic settle;
        push_max = 0; rdy_pct = 100; flush_pm = 0; ret_mode = 1; ret_pct = 100;
        cyc(40);
        ret_mode = 0;
    endtask

    initial begin
        errors = 0; checks = 0; seq = 8'h10;
        m_state = M_RUN; m_avail = CREDITS; m_vcnt = 0; acc_out = 0;
        rdy_pct = 100; flush_pm = 0; ret_mode = 0; ret_pct = 0;
        push_max = 0; push_n = 0; push_tok = 0; force_flush = 1'b0;
        rst = 1'b1;
        cyc(3);
        #1 rst = 1'b0;
        cyc(3);

        // Six entries, all credits, ready: pops of 4 then 2.
        push(6);
        cyc(6);
        settle();

        // Credit exhaustion: no returns, twelve entries queued.
        push(12);
        cyc(8);
        settle();

        // Backpressure with a full stage.
        rdy_pct = 0;
        push(8);
        cyc(7);
        rdy_pct = 100;
        cyc(4);
        settle();

        // Flush while two lanes are held unaccepted, other credits still out.
        push(4);
        cyc(4);
        rdy_pct = 0;
        push(2);
        cyc(4);
        force_flush = 1'b1;
        cyc(1);
        force_flush = 1'b0;
        cyc(6);
        rdy_pct = 100;
        ret_mode = 1;
        ret_pct = 100;
        cyc(10);
        settle();

        // Reset while waiting in DRAIN.
        push(4);
        cyc(4);
        force_flush = 1'b1;
        cyc(1);
        force_flush = 1'b0;
        for (int i = 0; i < 10 && m_state != M_DRAIN; i++) cyc(1);
        checks++;
        if (m_state != M_DRAIN) begin
            errors++;
            $display("FAIL drain_reach: state %0d expected %0d", m_state, M_DRAIN);
        end
        cyc(2);
        rst = 1'b1;
        cyc(1);
        #1 rst = 1'b0;
        cyc(4);

        // Saturation: one credit out, then four returned.
        push(1);
        cyc(4);
        ret_mode = 2;
        cyc(1);
        ret_mode = 0;
        cyc(3);

        // Random traffic.
        push_max = 3; rdy_pct = 70; flush_pm = 15; ret_mode = 1; ret_pct = 60;
        cyc(3000);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
